// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the unified I/D RAM arbiter.
//   state_t       : arbiter FSM encoding (ST_IDLE, ST_DM, ST_IF)
//   DEF_ADDR_W    : default byte-address width
//   DEF_DATA_W    : default word width
//   word_aligned(): true when the two address LSBs are zero
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DM   = 2'd1,
    ST_IF   = 2'd2
  } state_t;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_arb_fbuf.sv
// mem_arb_fbuf: one-entry fetch buffer (valid, word tag, data).
// Only instantiated when MEM_ARB_FETCH_BUF_EN is defined.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears valid)
//   fill              write fill_tag/fill_data and set valid
//   fill_tag/data     word address and instruction of a completed fetch
//   inv               store grant; clears valid when inv_tag matches
//   inv_tag           word address of the granted store
//   lookup_tag        word address of the pending fetch
//   hit, hit_data     lookup result (combinational)
module mem_arb_fbuf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill,
  input  logic [ADDR_W-3:0] fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inv,
  input  logic [ADDR_W-3:0] inv_tag,
  input  logic [ADDR_W-3:0] lookup_tag,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic              valid;
  logic [ADDR_W-3:0] tag;
  logic [DATA_W-1:0] data;

  // fill and inv never coincide: fills happen in IF_ACC, stores are granted in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end else if (inv && (inv_tag == tag)) begin
      valid <= 1'b0;
    end
  end

  assign hit      = valid && (tag == lookup_tag);
  assign hit_data = data;

endmodule

// File: rtl/mem_arb.sv
// mem_arb: arbiter/sequencer for the single-ported unified I/D RAM.
// Grants IF (fetch) and MEM (load/store) requests one at a time, data first,
// and drives the RAM through a registered req/ack handshake.
// Optional feature: define MEM_ARB_FETCH_BUF_EN to add a one-entry fetch buffer.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if_req/if_addr                  fetch request and PC
//   if_rdata/if_ready               fetched word, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata   data request (load/store)
//   dm_rdata/dm_ready/dm_err        load data, completion pulse, misaligned flag
//   mem_req/mem_we/mem_addr/mem_wdata  registered RAM request
//   mem_rdata/mem_ack               RAM read data and one-cycle completion
//   stall_if_req/stall_mem_req      per-stage stall requests to the hazard unit
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              dm_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if_req,
  output logic              stall_mem_req
);

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t            state;
  logic              discard;
  logic              fetch_moved;
  logic              fb_hit;
  logic [DATA_W-1:0] fb_data;

  // A requester keeps its request up during its ready cycle; masking with
  // ready keeps that stale request from being granted a second time.
  assign stall_if_req  = if_req & ~if_ready;
  assign stall_mem_req = dm_req & ~dm_ready;

  // Fetch was flushed or redirected while its RAM access is outstanding.
  assign fetch_moved = ~if_req | ((if_addr & WORD_MASK) != mem_addr);

`ifdef MEM_ARB_FETCH_BUF_EN
  logic fb_fill;
  logic fb_inv;

  assign fb_fill = (state == ST_IF) & mem_ack & ~discard & ~fetch_moved;
  assign fb_inv  = (state == ST_IDLE) & stall_mem_req & dm_we &
                   word_aligned(dm_addr[1:0]);

  mem_arb_fbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill       (fb_fill),
    .fill_tag   (mem_addr[ADDR_W-1:2]),
    .fill_data  (mem_rdata),
    .inv        (fb_inv),
    .inv_tag    (dm_addr[ADDR_W-1:2]),
    .lookup_tag (if_addr[ADDR_W-1:2]),
    .hit        (fb_hit),
    .hit_data   (fb_data)
  );
`else
  assign fb_hit  = 1'b0;
  assign fb_data = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      dm_err    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      discard   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      dm_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (stall_mem_req) begin
            if (!word_aligned(dm_addr[1:0])) begin
              // misaligned: answer with an error, never touch the RAM
              dm_ready <= 1'b1;
              dm_err   <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              state     <= ST_DM;
            end
          end else if (stall_if_req) begin
            if (fb_hit) begin
              if_ready <= 1'b1;
              if_rdata <= fb_data;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= if_addr & WORD_MASK;
              state    <= ST_IF;
            end
          end
        end
        ST_DM: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            dm_rdata <= mem_rdata;
            dm_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_IF: begin
          if (fetch_moved) discard <= 1'b1;
          if (mem_ack) begin
            // the RAM access always runs to completion; a flushed fetch
            // just swallows its data
            mem_req <= 1'b0;
            state   <= ST_IDLE;
            discard <= 1'b0;
            if (!discard && !fetch_moved) begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
`timescale 1ns/1ps
module tb_mem_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          if_ready, dm_ready, dm_err;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          stall_if_req, stall_mem_req;

  mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_rdata      (if_rdata),
    .if_ready      (if_ready),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_rdata      (dm_rdata),
    .dm_ready      (dm_ready),
    .dm_err        (dm_err),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .stall_if_req  (stall_if_req),
    .stall_mem_req (stall_mem_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
    logic          chk;
  } exp_t;

  exp_t if_q[$];
  exp_t dm_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // RAM model: sparse storage, default word derived from the address
  logic [DW-1:0] ram [int unsigned];
  int ack_dly = 1;
  int ram_cnt = 0;

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    if (ram.exists(a)) return ram[a];
    return 32'h1000_0000 + a * 3;
  endfunction

  // ack arrives in the ack_dly-th cycle that mem_req is high
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_ack = 1'b0;
        ram_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        ram_cnt++;
        if (ram_cnt >= ack_dly) begin
          ram_cnt   = 0;
          mem_ack   = 1'b1;
          mem_rdata = word_at(mem_addr);
          if (mem_we) ram[mem_addr] = mem_wdata;
        end
      end else begin
        ram_cnt = 0;
      end
    end
  end

  // scoreboard: every ready pulse pops the oldest expectation of its requester
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (if_ready && dm_ready) begin
          n_vec++; n_err++;
          $display("FAIL both_ready: if_ready=1 dm_ready=1, required at most one");
        end
        if (dm_ready) begin
          n_vec++;
          if (dm_q.size() == 0) begin
            n_err++;
            $display("FAIL dm_unexpected: rdata=%h err=%b, required no pulse", dm_rdata, dm_err);
          end else begin
            e = dm_q.pop_front();
            if (dm_err !== e.err || (e.chk && dm_rdata !== e.data)) begin
              n_err++;
              $display("FAIL dm_result: rdata=%h err=%b, required rdata=%h err=%b",
                       dm_rdata, dm_err, e.data, e.err);
            end
          end
        end
        if (if_ready) begin
          n_vec++;
          if (if_q.size() == 0) begin
            n_err++;
            $display("FAIL if_unexpected: rdata=%h, required no pulse", if_rdata);
          end else begin
            e = if_q.pop_front();
            if (if_rdata !== e.data) begin
              n_err++;
              $display("FAIL if_result: rdata=%h, required %h", if_rdata, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // drives one fetch, returns cycles to if_ready (-1 on timeout) and mem_req cycles
  task automatic run_fetch(input logic [AW-1:0] a, output int lat, output int reqc);
    exp_t e;
    e.data = word_at(a); e.err = 1'b0; e.chk = 1'b1;
    if_q.push_back(e);
    if_addr = a; if_req = 1'b1;
    lat = -1; reqc = 0;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (mem_req) reqc++;
      if (if_ready) begin lat = c; break; end
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req = 1'b1;
    #1;
    n_vec++;
    if (stall_if_req !== 1'b1) begin
      n_err++; $display("FAIL rst_stall_if: got %b, required 1", stall_if_req);
    end
    repeat (2) cyc();
    n_vec++;
    if ({mem_req, mem_we, if_ready, dm_ready, dm_err} !== 5'b0) begin
      n_err++; $display("FAIL rst_ctrl: got %b, required 00000",
                        {mem_req, mem_we, if_ready, dm_ready, dm_err});
    end
    n_vec++;
    if (mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || dm_rdata !== '0) begin
      n_err++; $display("FAIL rst_data: addr=%h wdata=%h ird=%h drd=%h, required 0",
                        mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    if_req = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_load();
    int reqc, ackc, rdyc;
    bit stall_ok;
    logic [AW-1:0] g_addr;
    logic g_we;
    exp_t e;
    reqc = 0; ackc = -1; rdyc = -1; stall_ok = 1'b1; g_addr = 'x; g_we = 1'bx;
    ack_dly = 2;
    e.data = word_at(32'h10); e.err = 1'b0; e.chk = 1'b1;
    dm_q.push_back(e);
    dm_we = 1'b0; dm_addr = 32'h10; dm_wdata = '0; dm_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (mem_req) begin
        reqc++;
        if (reqc == 1) begin g_addr = mem_addr; g_we = mem_we; end
      end
      if (mem_ack) ackc = c;
      if (dm_ready) begin rdyc = c; break; end
      if (stall_mem_req !== 1'b1) stall_ok = 1'b0;
    end
    n_vec++;
    if (stall_mem_req !== 1'b0) begin
      n_err++; $display("FAIL ld_stall_at_ready: got %b, required 0", stall_mem_req);
    end
    dm_req = 1'b0;
    n_vec++;
    if (reqc != 2) begin n_err++; $display("FAIL ld_req_cycles: got %0d, required 2", reqc); end
    n_vec++;
    if (g_addr !== 32'h10 || g_we !== 1'b0) begin
      n_err++; $display("FAIL ld_grant: addr=%h we=%b, required 00000010/0", g_addr, g_we);
    end
    n_vec++;
    if (rdyc < 0 || rdyc != ackc + 1) begin
      n_err++; $display("FAIL ld_ready_timing: ready cycle %0d, required %0d", rdyc, ackc + 1);
    end
    n_vec++;
    if (!stall_ok) begin n_err++; $display("FAIL ld_stall: got 0 before ready, required 1"); end
    cyc();
  endtask

  task automatic test_flush();
    int grants, g2c, ifc;
    logic prev;
    logic [AW-1:0] g2_addr;
    exp_t e;
    grants = 0; g2c = -1; ifc = -1; prev = 1'b0; g2_addr = 'x;
    ack_dly = 4;
    if_addr = 32'h40; if_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (mem_req && !prev) begin
        grants++;
        if (grants == 2) begin g2_addr = mem_addr; g2c = c; end
      end
      prev = mem_req;
      if (if_ready) begin ifc = c; break; end
      if (c == 2) begin
        e.data = word_at(32'h100); e.err = 1'b0; e.chk = 1'b1;
        if_q.push_back(e);
        if_addr = 32'h100;
      end
    end
    if_req = 1'b0;
    n_vec++;
    if (grants != 2) begin n_err++; $display("FAIL fl_grants: got %0d, required 2", grants); end
    n_vec++;
    if (g2_addr !== 32'h100) begin
      n_err++; $display("FAIL fl_addr: got %h, required 00000100", g2_addr);
    end
    n_vec++;
    if (ifc < 0 || ifc != g2c + 4) begin
      n_err++; $display("FAIL fl_ready_timing: got %0d, required %0d", ifc, g2c + 4);
    end
    cyc();
  endtask

  task automatic test_priority();
    int grants, dmc, fic, ifc;
    logic prev, g1_we, g2_we;
    logic [AW-1:0] g1_addr, g2_addr;
    logic [DW-1:0] g1_wd;
    exp_t e;
    grants = 0; dmc = -1; fic = -1; ifc = -1; prev = 1'b0;
    g1_we = 1'bx; g2_we = 1'bx; g1_addr = 'x; g2_addr = 'x; g1_wd = 'x;
    ack_dly = 1;
    e.data = '0; e.err = 1'b0; e.chk = 1'b0;
    dm_q.push_back(e);
    e.data = word_at(32'h40); e.chk = 1'b1;
    if_q.push_back(e);
    if_addr = 32'h40; if_req = 1'b1;
    dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      if (mem_req && !prev) begin
        grants++;
        if (grants == 1) begin g1_we = mem_we; g1_addr = mem_addr; g1_wd = mem_wdata; end
        if (grants == 2) begin g2_we = mem_we; g2_addr = mem_addr; fic = c; end
      end
      prev = mem_req;
      if (dm_ready) begin dmc = c; dm_req = 1'b0; end
      if (if_ready) begin ifc = c; break; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    n_vec++;
    if (g1_we !== 1'b1 || g1_addr !== 32'h80 || g1_wd !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL pr_first_grant: we=%b addr=%h wd=%h, required 1/00000080/deadbeef",
                        g1_we, g1_addr, g1_wd);
    end
    n_vec++;
    if (g2_we !== 1'b0 || g2_addr !== 32'h40) begin
      n_err++; $display("FAIL pr_second_grant: we=%b addr=%h, required 0/00000040", g2_we, g2_addr);
    end
    n_vec++;
    if (dmc < 0 || fic != dmc + 1) begin
      n_err++; $display("FAIL pr_bubble: fetch grant cycle %0d, required %0d", fic, dmc + 1);
    end
    n_vec++;
    if (ifc < 0 || ifc != fic + 1) begin
      n_err++; $display("FAIL pr_if_ready: got %0d, required %0d", ifc, fic + 1);
    end
    n_vec++;
    if (word_at(32'h80) !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL pr_ram_write: got %h, required deadbeef", word_at(32'h80));
    end
    cyc();
  endtask

  task automatic test_misaligned();
    int reqc, rdyc;
    logic err_at;
    exp_t e;
    reqc = 0; rdyc = -1; err_at = 1'bx;
    e.data = '0; e.err = 1'b1; e.chk = 1'b0;
    dm_q.push_back(e);
    dm_we = 1'b0; dm_addr = 32'h13; dm_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (mem_req) reqc++;
      if (dm_ready && rdyc < 0) begin rdyc = c; err_at = dm_err; dm_req = 1'b0; end
    end
    dm_req = 1'b0;
    n_vec++;
    if (rdyc != 1 || err_at !== 1'b1) begin
      n_err++; $display("FAIL mis_ready: cycle %0d err=%b, required 1/1", rdyc, err_at);
    end
    n_vec++;
    if (reqc != 0) begin n_err++; $display("FAIL mis_mem_req: got %0d cycles, required 0", reqc); end
  endtask

  task automatic test_reset_mid();
    int lat, reqc;
    ack_dly = 6;
    dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h1234_5678; dm_req = 1'b1;
    cyc(); cyc();
    n_vec++;
    if (mem_req !== 1'b1 || mem_wdata !== 32'h1234_5678) begin
      n_err++; $display("FAIL rm_in_flight: req=%b wd=%h, required 1/12345678", mem_req, mem_wdata);
    end
    rst_n = 1'b0; dm_req = 1'b0;
    #1;
    n_vec++;
    if ({mem_req, mem_we, if_ready, dm_ready, dm_err} !== 5'b0) begin
      n_err++; $display("FAIL rm_ctrl: got %b, required 00000",
                        {mem_req, mem_we, if_ready, dm_ready, dm_err});
    end
    n_vec++;
    if (mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || dm_rdata !== '0) begin
      n_err++; $display("FAIL rm_data: addr=%h wd=%h ird=%h drd=%h, required 0",
                        mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    cyc();
    rst_n = 1'b1;
    ack_dly = 1;
    cyc();
    n_vec++;
    if (ram.exists(32'h20)) begin
      n_err++; $display("FAIL rm_abandoned: store written, required no write");
    end
    run_fetch(32'h200, lat, reqc);
    n_vec++;
    if (lat != 2 || reqc != 1) begin
      n_err++; $display("FAIL rm_fetch: lat=%0d req=%0d, required 2/1", lat, reqc);
    end
    cyc();
  endtask

  task automatic test_fetch_buf();
    int lat, reqc, rdyc;
    exp_t e;
    ack_dly = 2;
    run_fetch(32'h300, lat, reqc);
    n_vec++;
    if (lat != 3 || reqc != 2) begin
      n_err++; $display("FAIL fb_first: lat=%0d req=%0d, required 3/2", lat, reqc);
    end
    cyc();
    run_fetch(32'h300, lat, reqc);
`ifdef MEM_ARB_FETCH_BUF_EN
    n_vec++;
    if (lat != 1 || reqc != 0) begin
      n_err++; $display("FAIL fb_hit: lat=%0d req=%0d, required 1/0", lat, reqc);
    end
`else
    n_vec++;
    if (lat != 3 || reqc != 2) begin
      n_err++; $display("FAIL fb_refetch: lat=%0d req=%0d, required 3/2", lat, reqc);
    end
`endif
    cyc();
    e.data = '0; e.err = 1'b0; e.chk = 1'b0;
    dm_q.push_back(e);
    dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'hCAFE_F00D; dm_req = 1'b1;
    rdyc = -1;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (dm_ready) begin rdyc = c; break; end
    end
    dm_req = 1'b0;
    n_vec++;
    if (rdyc != 3) begin n_err++; $display("FAIL fb_store: ready cycle %0d, required 3", rdyc); end
    cyc();
    run_fetch(32'h300, lat, reqc);
    n_vec++;
    if (lat != 3 || reqc != 2) begin
      n_err++; $display("FAIL fb_after_store: lat=%0d req=%0d, required 3/2", lat, reqc);
    end
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    test_reset();
    test_load();
    test_flush();
    test_priority();
    test_misaligned();
    test_reset_mid();
    test_fetch_buf();
    repeat (3) cyc();
    n_vec++;
    if (if_q.size() != 0 || dm_q.size() != 0) begin
      n_err++; $display("FAIL sb_drain: %0d if / %0d dm pending, required 0/0",
                        if_q.size(), dm_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
